count_sequencer: RTL and testbench

Controller that owns a WIDTH-bit step counter and sequences it through programmed runs: load a start value, count up or down to a terminal value, repeat a programmed number of times, then signal completion. It sits beside the toggle-flip-flop counter datapath and gives software or upstream logic a start/stop/done handshake in place of free-running counting. All state is clocked on clk.

---
 rtl/count_sequencer.sv | 174 +++++++++++++++++
 tb/tb_count_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// count_sequencer: sequences a WIDTH-bit step counter through programmed runs.
// Each run loads a start value, counts up or down to a terminal value, and is
// repeated reps+1 times. done pulses once after the last run. stop aborts.
//
// Ports:
//   clk      - clock, all state on rising edge
//   rst      - asynchronous active-high reset
//   start    - request a sequence (IDLE only)
//   stop     - abort request (LOAD and RUN)
//   up       - direction: 1 = count up, 0 = count down
//   limit    - terminal value (up) or start value (down)
//   reps     - extra repetitions; total runs = reps+1
//   pause    - (COUNT_SEQ_PAUSE_EN only) hold the counter while in RUN
//   q        - counter value (registered)
//   tc       - terminal count, decoded from state and q (combinational)
//   busy     - high in LOAD and RUN (registered)
//   done     - one-cycle completion pulse (registered)
//   rep_cnt  - index of the current run (registered)
//
// Optional feature macro: COUNT_SEQ_PAUSE_EN adds the pause input.

module count_sequencer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned NREP_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              up,
    input  logic [WIDTH-1:0]  limit,
    input  logic [NREP_W-1:0] reps,
`ifdef COUNT_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              busy,
    output logic              done,
    output logic [NREP_W-1:0] rep_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_q;
    logic [NREP_W-1:0] r_rep;
    logic              r_busy;
    logic              r_done;
    logic              r_up_s;
    logic [WIDTH-1:0]  r_limit_s;
    logic [NREP_W-1:0] r_reps_s;

    logic [1:0]        w_state_nxt;
    logic [WIDTH-1:0]  w_q_nxt;
    logic [NREP_W-1:0] w_rep_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_up_nxt;
    logic [WIDTH-1:0]  w_limit_nxt;
    logic [NREP_W-1:0] w_reps_nxt;

    logic [WIDTH-1:0]  w_end_val;
    logic [WIDTH-1:0]  w_start_val;
    logic              w_at_end;
    logic              w_pause;

`ifdef COUNT_SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // End and reload values come only from the shadow copies.
    assign w_end_val   = r_up_s ? r_limit_s : '0;
    assign w_start_val = r_up_s ? '0 : r_limit_s;
    assign w_at_end    = (r_q == w_end_val);

    assign tc      = (r_state == S_RUN) && w_at_end && !w_pause;
    assign q       = r_q;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rep_cnt = r_rep;

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_rep     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_up_s    <= 1'b0;
            r_limit_s <= '0;
            r_reps_s  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_rep     <= w_rep_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_up_s    <= w_up_nxt;
            r_limit_s <= w_limit_nxt;
            r_reps_s  <= w_reps_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rep_nxt   = r_rep;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_up_nxt    = r_up_s;
        w_limit_nxt = r_limit_s;
        w_reps_nxt  = r_reps_s;

        case (r_state)
            S_IDLE: begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    w_up_nxt    = up;
                    w_limit_nxt = limit;
                    w_reps_nxt  = reps;
                    w_state_nxt = S_LOAD;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_q_nxt     = w_start_val;
                    w_rep_nxt   = '0;
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pause) begin
                    w_busy_nxt = 1'b1;
                end else if (w_at_end) begin
                    if (r_rep == r_reps_s) begin
                        // q keeps the end value through DONE
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // back-to-back reload, no idle cycle between runs
                        w_rep_nxt  = r_rep + NREP_W'(1);
                        w_q_nxt    = w_start_val;
                        w_busy_nxt = 1'b1;
                    end
                end else begin
                    // never reached at the end value, so no wrap is possible
                    w_q_nxt    = r_up_s ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
                    w_busy_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

    localparam int unsigned W = 4;
    localparam int unsigned N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, stop, up, pause;
    logic [W-1:0] limit;
    logic [N-1:0] reps;
    logic [W-1:0] q;
    logic         tc, busy, done;
    logic [N-1:0] rep_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    count_sequencer #(.WIDTH(W), .NREP_W(N)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .up(up),
        .limit(limit), .reps(reps),
`ifdef COUNT_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .q(q), .tc(tc), .busy(busy), .done(done), .rep_cnt(rep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic pause_eff();
`ifdef COUNT_SEQ_PAUSE_EN
        return pause;
`else
        return 1'b0;
`endif
    endfunction

    // Model: one record per cycle describing the expected outputs.
    typedef struct packed {
        logic [W-1:0] q;
        logic [N-1:0] rep;
        logic         busy;
        logic         done;
        logic         run;
        logic         tc;
    } rec_t;

    rec_t cur = '0;
    rec_t plan[$];

    // On an accepted start, lay out the whole sequence as a timeline.
    task automatic build_plan(input logic u, input int l, input int r);
        rec_t x;
        plan.delete();
        for (int rr = 0; rr <= r; rr++) begin
            for (int k = 0; k <= l; k++) begin
                x      = '0;
                x.q    = u ? W'(k) : W'(l - k);
                x.rep  = N'(rr);
                x.busy = 1'b1;
                x.run  = 1'b1;
                x.tc   = (k == l);
                plan.push_back(x);
            end
        end
        x      = '0;
        x.q    = u ? W'(l) : W'(0);
        x.rep  = N'(r);
        x.done = 1'b1;
        plan.push_back(x);
    endtask

    always @(posedge clk) begin
        rec_t nx;
        if (rst) begin
            cur = '0;
            plan.delete();
        end else if (cur.busy && stop) begin
            plan.delete();
            nx = '0; nx.q = cur.q; nx.rep = cur.rep;
            cur = nx;
        end else if (cur.run && pause_eff()) begin
            cur = cur;
        end else if (plan.size() > 0) begin
            cur = plan.pop_front();
        end else if (!cur.busy && !cur.done && start && !stop) begin
            build_plan(up, int'(limit), int'(reps));
            nx = '0; nx.q = cur.q; nx.rep = cur.rep; nx.busy = 1'b1;
            cur = nx;
        end else begin
            nx = '0; nx.q = cur.q; nx.rep = cur.rep;
            cur = nx;
        end
        #3;
        chk("q", int'(q), int'(cur.q));
        chk("rep_cnt", int'(rep_cnt), int'(cur.rep));
        chk("busy", int'(busy), int'(cur.busy));
        chk("done", int'(done), int'(cur.done));
        chk("tc", int'(tc), int'(cur.run && cur.tc && !pause_eff()));
    end

    // Starts a sequence at a negedge and counts cycles from the start edge
    // to the done pulse, plus tc cycles seen on the way.
    task automatic run_seq(input logic u, input int l, input int r,
                           input int pause_q, input logic poke,
                           output int cyc, output int tcs);
        int pc;
        start = 1'b1; up = u; limit = W'(l); reps = N'(r);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; tcs = 0; pc = 0;
        while (1) begin
            if (tc) tcs++;
            if (done) break;
            if (cyc > 200) begin
                chk("done_timeout", cyc, -1);
                break;
            end
            if (pause_q >= 0 && cyc > 0 && busy && int'(q) == pause_q && pc < 3) begin
                pause = 1'b1;
                pc++;
            end else begin
                pause = 1'b0;
            end
            if (poke && cyc == 3) begin
                start = 1'b1; up = ~u; limit = ~limit; reps = '0;
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        pause = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int cyc, tcs, guard;
        rst = 1'b1; start = 1'b0; stop = 1'b0; up = 1'b0; pause = 1'b0;
        limit = '0; reps = '0;
        repeat (3) @(negedge clk);
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Up run, limit 3, single run
        run_seq(1'b1, 3, 0, -1, 1'b0, cyc, tcs);
        chk("up_cycles", cyc, 5);
        chk("up_tcs", tcs, 1);
        chk("up_q_end", int'(q), 3);
        @(negedge clk);
        chk("up_q_hold", int'(q), 3);

        // Down run, limit 2, three runs
        run_seq(1'b0, 2, 2, -1, 1'b0, cyc, tcs);
        chk("down_cycles", cyc, 10);
        chk("down_tcs", tcs, 3);
        chk("down_q_end", int'(q), 0);
        chk("down_rep_end", int'(rep_cnt), 2);
        @(negedge clk);

        // limit 0: every RUN cycle is a tc cycle
        run_seq(1'b1, 0, 3, -1, 1'b0, cyc, tcs);
        chk("lim0_cycles", cyc, 5);
        chk("lim0_tcs", tcs, 4);
        @(negedge clk);

        // start and input changes mid-run are ignored
        run_seq(1'b1, 4, 1, -1, 1'b1, cyc, tcs);
        chk("poke_cycles", cyc, 11);
        chk("poke_tcs", tcs, 2);
        chk("poke_q_end", int'(q), 4);
        @(negedge clk);

        // Abort at q=2 in an up run with limit 5
        start = 1'b1; up = 1'b1; limit = W'(5); reps = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!(busy && q == W'(2)) && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        chk("abort_reach_q2", guard < 50 ? 1 : 0, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q", int'(q), 2);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", int'(done), 0);
            @(negedge clk);
        end
        run_seq(1'b1, 3, 0, -1, 1'b0, cyc, tcs);
        chk("restart_cycles", cyc, 5);
        @(negedge clk);

        // start and stop together in IDLE: stay idle
        start = 1'b1; stop = 1'b1; up = 1'b0; limit = W'(6);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", int'(busy), 0);
        @(negedge clk);
        chk("ss_busy2", int'(busy), 0);
        chk("ss_q", int'(q), 3);

`ifdef COUNT_SEQ_PAUSE_EN
        // Pause three cycles at q=1
        run_seq(1'b1, 3, 0, 1, 1'b0, cyc, tcs);
        chk("pause_cycles", cyc, 8);
        chk("pause_tcs", tcs, 1);
        @(negedge clk);
`endif

        // Asynchronous reset in the middle of a run
        start = 1'b1; up = 1'b1; limit = W'(7); reps = N'(1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_tc", int'(tc), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
